// File: rtl/tpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_sequencer
// Purpose  : Control-plane sequencer for the systolic array (top_tpu). Holds
//            the run configuration written through the CONTROL window and
//            steps the array through weight load, input-FIFO load, multiply
//            and drain, reporting busy/done/err and a run-cycle count.
// Revision : 1.0 - initial release
// Option   : define TPU_SEQ_IRQ_EN to add the irq output and CTRL bit2 irq_en.
//
// Ports
//   clk                in   system clock, rising edge
//   reset_n            in   asynchronous active-low reset
//   cfg_wr             in   one-cycle register write strobe
//   cfg_addr[1:0]      in   0=CTRL 1=WBASE 2=IBASE 3=NUM_ROWS
//   cfg_wdata[31:0]    in   write data
//   status[31:0]       out  {cyc_cnt[15:0], 10'b0, state[2:0], err, done, busy}
//   ld_weights         out  high on every weight-load beat
//   ld_fifo            out  high on every input-FIFO load beat
//   mult_en            out  high on every multiply/drain cycle
//   base_addr_weights  out  WBASE+k during LOAD_W, else 0
//   base_addr_input    out  IBASE+k during LOAD_IN, else 0
//   irq                out  (TPU_SEQ_IRQ_EN only) registered done & irq_en
// ============================================================================
module tpu_sequencer #(
  parameter int ARRAY_DIM  = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int ROW_WIDTH  = 8,
  parameter int CYC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_wr,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [31:0]           status,
  output logic                  ld_weights,
  output logic                  ld_fifo,
  output logic                  mult_en,
  output logic [ADDR_WIDTH-1:0] base_addr_weights,
  output logic [ADDR_WIDTH-1:0] base_addr_input
`ifdef TPU_SEQ_IRQ_EN
  ,
  output logic                  irq
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_IN = 3'd2,
    S_MULT    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Beat counter for the two load phases, and a wider counter for the
  // multiply phase, which lasts NUM_ROWS + 2*ARRAY_DIM - 1 cycles.
  localparam int KW  = ADDR_WIDTH + 1;
  localparam int MCW = ROW_WIDTH + $clog2(2 * ARRAY_DIM) + 1;

  localparam logic [KW-1:0]        c_K_LAST   = KW'(ARRAY_DIM - 1);
  localparam logic [KW-1:0]        c_K_ONE    = KW'(1);
  localparam logic [MCW-1:0]       c_DRAIN    = MCW'(2 * ARRAY_DIM - 2);
  localparam logic [MCW-1:0]       c_MCNT_ONE = MCW'(1);
  localparam logic [CYC_WIDTH-1:0] c_CYC_ONE  = CYC_WIDTH'(1);
  localparam logic [CYC_WIDTH-1:0] c_CYC_MAX  = '1;

  state_t                r_state, w_state_nxt;
  logic [KW-1:0]         r_k, w_k_nxt;
  logic [MCW-1:0]        r_mcnt, w_mcnt_nxt;
  logic [CYC_WIDTH-1:0]  r_cyc, w_cyc_nxt;
  logic                  r_err, w_err_nxt;
  logic                  r_done, w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_wbase, r_ibase;
  logic [ROW_WIDTH-1:0]  r_num_rows;
  logic                  r_ld_w, w_ld_w_nxt;
  logic                  r_ld_f, w_ld_f_nxt;
  logic                  r_mult, w_mult_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_w, w_addr_w_nxt;
  logic [ADDR_WIDTH-1:0] r_addr_i, w_addr_i_nxt;

  logic                  w_ctrl_wr, w_abort, w_start, w_clr, w_busy;
  logic [MCW-1:0]        w_mult_last;
  logic [15:0]           w_cyc16;
  logic                  w_unused;

  // CTRL decode: abort masks start and done_clr in the same write.
  assign w_ctrl_wr   = cfg_wr && (cfg_addr == 2'd0);
  assign w_abort     = w_ctrl_wr && cfg_wdata[1];
  assign w_start     = w_ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign w_clr       = w_ctrl_wr && cfg_wdata[3] && !cfg_wdata[1];
  assign w_busy      = (r_state == S_LOAD_W) || (r_state == S_LOAD_IN) ||
                       (r_state == S_MULT);
  assign w_mult_last = MCW'(r_num_rows) + c_DRAIN;
  assign w_unused    = ^cfg_wdata;

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_mcnt_nxt  = r_mcnt;
    w_cyc_nxt   = r_cyc;
    w_err_nxt   = r_err;
    w_done_nxt  = r_done;

    if (w_busy && (r_cyc != c_CYC_MAX)) begin
      w_cyc_nxt = r_cyc + c_CYC_ONE;
    end

    if (w_clr) begin
      w_err_nxt  = 1'b0;
      w_done_nxt = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (r_num_rows == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = S_LOAD_W;
            w_k_nxt     = '0;
            w_cyc_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
          end
        end
      end
      S_LOAD_W: begin
        if (r_k == c_K_LAST) begin
          w_state_nxt = S_LOAD_IN;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + c_K_ONE;
        end
      end
      S_LOAD_IN: begin
        if (r_k == c_K_LAST) begin
          w_state_nxt = S_MULT;
          w_k_nxt     = '0;
          w_mcnt_nxt  = '0;
        end else begin
          w_k_nxt = r_k + c_K_ONE;
        end
      end
      S_MULT: begin
        if (r_mcnt == w_mult_last) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_mcnt_nxt = r_mcnt + c_MCNT_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_abort && w_busy) begin
      w_state_nxt = S_IDLE;
      w_k_nxt     = '0;
      w_err_nxt   = 1'b1;
    end

    // Strobes and addresses are computed from the next state so that the
    // registered outputs line up with the state they belong to.
    w_ld_w_nxt   = (w_state_nxt == S_LOAD_W);
    w_ld_f_nxt   = (w_state_nxt == S_LOAD_IN);
    w_mult_nxt   = (w_state_nxt == S_MULT);
    w_addr_w_nxt = w_ld_w_nxt ? (r_wbase + w_k_nxt[ADDR_WIDTH-1:0]) : '0;
    w_addr_i_nxt = w_ld_f_nxt ? (r_ibase + w_k_nxt[ADDR_WIDTH-1:0]) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_mcnt   <= '0;
      r_cyc    <= '0;
      r_err    <= 1'b0;
      r_done   <= 1'b0;
      r_ld_w   <= 1'b0;
      r_ld_f   <= 1'b0;
      r_mult   <= 1'b0;
      r_addr_w <= '0;
      r_addr_i <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_k      <= w_k_nxt;
      r_mcnt   <= w_mcnt_nxt;
      r_cyc    <= w_cyc_nxt;
      r_err    <= w_err_nxt;
      r_done   <= w_done_nxt;
      r_ld_w   <= w_ld_w_nxt;
      r_ld_f   <= w_ld_f_nxt;
      r_mult   <= w_mult_nxt;
      r_addr_w <= w_addr_w_nxt;
      r_addr_i <= w_addr_i_nxt;
    end
  end

  // Run configuration is frozen while busy so a run uses the values it
  // started with.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbase    <= '0;
      r_ibase    <= '0;
      r_num_rows <= '0;
    end else if (cfg_wr && !w_busy) begin
      case (cfg_addr)
        2'd1:    r_wbase    <= cfg_wdata[ADDR_WIDTH-1:0];
        2'd2:    r_ibase    <= cfg_wdata[ADDR_WIDTH-1:0];
        2'd3:    r_num_rows <= cfg_wdata[ROW_WIDTH-1:0];
        default: ;
      endcase
    end
  end

`ifdef TPU_SEQ_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_irq_en <= cfg_wdata[2];
      end
      // done_clr must drop irq on the same edge that clears done.
      if (w_clr) begin
        r_irq <= 1'b0;
      end else begin
        r_irq <= r_done & r_irq_en;
      end
    end
  end

  assign irq = r_irq;
`endif

  generate
    if (CYC_WIDTH >= 16) begin : g_cyc_trunc
      assign w_cyc16 = r_cyc[15:0];
    end else begin : g_cyc_pad
      assign w_cyc16 = {{(16 - CYC_WIDTH){1'b0}}, r_cyc};
    end
  endgenerate

  assign status            = {w_cyc16, 10'b0, r_state, r_err, r_done, w_busy};
  assign ld_weights        = r_ld_w;
  assign ld_fifo           = r_ld_f;
  assign mult_en           = r_mult;
  assign base_addr_weights = r_addr_w;
  assign base_addr_input   = r_addr_i;

endmodule
`default_nettype wire

// File: tb/tb_tpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_sequencer
// Purpose  : Self-checking bench for tpu_sequencer (ARRAY_DIM=4). Expected
//            outputs come from a per-cycle timeline model computed from the
//            run parameters (offset from the start write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_sequencer;
  localparam int AD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] status;
  logic        ld_weights, ld_fifo, mult_en;
  logic [7:0]  base_addr_weights, base_addr_input;
`ifdef TPU_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpu_sequencer #(
    .ARRAY_DIM (AD),
    .ADDR_WIDTH(8),
    .ROW_WIDTH (8),
    .CYC_WIDTH (16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_wr           (cfg_wr),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .status           (status),
    .ld_weights       (ld_weights),
    .ld_fifo          (ld_fifo),
    .mult_en          (mult_en),
    .base_addr_weights(base_addr_weights),
    .base_addr_input  (base_addr_input)
`ifdef TPU_SEQ_IRQ_EN
    ,
    .irq              (irq)
`endif
  );

  // Observed output bundle: {status, ld_weights, ld_fifo, mult_en, aw, ai}.
  logic [50:0] obs;
  assign obs = {status, ld_weights, ld_fifo, mult_en, base_addr_weights, base_addr_input};

  // Expected bundle for cycle T+d of a run started at T (d >= 1).
  // Status fields: cyc[31:16], state[5:3], err[2], done[1], busy[0].
  function automatic logic [50:0] model(input int d, input logic [7:0] w,
                                        input logic [7:0] ib, input int n);
    int         busy_len;
    int         cyc;
    logic [2:0] st;
    logic       ldw, ldf, me, dn, bz;
    logic [7:0] aw, ai;
    busy_len = 4 * AD + n - 1;
    ldw = 1'b0; ldf = 1'b0; me = 1'b0; dn = 1'b0;
    aw = 8'h00; ai = 8'h00;
    if (d <= AD) begin
      st = 3'd1; ldw = 1'b1; aw = w + 8'(d - 1);
    end else if (d <= 2 * AD) begin
      st = 3'd2; ldf = 1'b1; ai = ib + 8'(d - AD - 1);
    end else if (d <= busy_len) begin
      st = 3'd3; me = 1'b1;
    end else if (d == busy_len + 1) begin
      st = 3'd4; dn = 1'b1;
    end else begin
      st = 3'd0; dn = 1'b1;
    end
    bz  = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
    cyc = (d - 1 < busy_len) ? d - 1 : busy_len;
    return {16'(cyc), 10'b0, st, 1'b0, dn, bz, ldw, ldf, me, aw, ai};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] dat);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = dat;
    step();
    cfg_wr    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    checks++;
    if (obs !== 51'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", obs, 51'b0);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (obs !== 51'b0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, 51'b0);
    end
  endtask

  task automatic test_zero_rows();
    cfg_write(2'd0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== {32'h0000_0004, 19'b0}) begin
        failures++;
        $display("FAIL zero_rows i=%0d got=%h exp=%h", i, obs, {32'h0000_0004, 19'b0});
      end
      step();
    end
  endtask

  task automatic test_nominal();
    logic [50:0] e;
    cfg_write(2'd1, 32'h10);
    cfg_write(2'd2, 32'h20);
    cfg_write(2'd3, 32'd3);
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 21; d++) begin
      e = model(d, 8'h10, 8'h20, 3);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL nominal d=%0d got=%h exp=%h", d, obs, e);
      end
      // DONE: cyc=18, state=4 at [5:3], done=1.
      if (d == 19) begin
        checks++;
        if (status !== 32'h0012_0022) begin
          failures++;
          $display("FAIL nominal_done_status got=%h exp=%h", status, 32'h0012_0022);
        end
      end
      if (d == 20) begin
        checks++;
        if (status !== 32'h0012_0002) begin
          failures++;
          $display("FAIL nominal_idle_status got=%h exp=%h", status, 32'h0012_0002);
        end
      end
      step();
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  tab [4];
    logic [7:0]  ib;
    logic [50:0] e;
    int          n;
    tab[0] = 8'hFE; tab[1] = 8'hFF; tab[2] = 8'h00; tab[3] = 8'h01;
    ib = 8'($urandom);
    n  = int'($urandom_range(1, 5));
    cfg_write(2'd1, 32'hFE);
    cfg_write(2'd2, {24'h0, ib});
    cfg_write(2'd3, 32'(n));
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 4 * AD + n + 1; d++) begin
      e = model(d, 8'hFE, ib, n);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL wrap d=%0d got=%h exp=%h", d, obs, e);
      end
      if (d <= 4) begin
        checks++;
        if (base_addr_weights !== tab[d-1]) begin
          failures++;
          $display("FAIL wrap_addr d=%0d got=%h exp=%h", d, base_addr_weights, tab[d-1]);
        end
      end
      step();
    end
  endtask

  task automatic test_busy_writes();
    logic [50:0] e;
    cfg_write(2'd1, 32'h40);
    cfg_write(2'd2, 32'h50);
    cfg_write(2'd3, 32'd2);
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 4 * AD + 2 + 1; d++) begin
      e = model(d, 8'h40, 8'h50, 2);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL busy_writes d=%0d got=%h exp=%h", d, obs, e);
      end
      cfg_wr = 1'b0;
      if (d == 3) begin
        cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h1;
      end
      if (d == 6) begin
        cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'h77;
      end
      step();
    end
    cfg_wr = 1'b0;
    // WBASE write made while busy was dropped; run again with the old base.
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 4 * AD + 2 + 1; d++) begin
      e = model(d, 8'h40, 8'h50, 2);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL busy_writes_next d=%0d got=%h exp=%h", d, obs, e);
      end
      step();
    end
  endtask

  task automatic test_abort();
    logic [50:0] e;
    cfg_write(2'd1, 32'h10);
    cfg_write(2'd2, 32'h20);
    cfg_write(2'd3, 32'd3);
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 12; d++) begin
      e = model(d, 8'h10, 8'h20, 3);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort_pre d=%0d got=%h exp=%h", d, obs, e);
      end
      if (d == 12) begin
        cfg_wr = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'h2;
      end
      step();
    end
    cfg_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== {32'h000C_0004, 19'b0}) begin
        failures++;
        $display("FAIL abort_post i=%0d got=%h exp=%h", i, obs, {32'h000C_0004, 19'b0});
      end
      step();
    end
    cfg_write(2'd0, 32'h8);
    checks++;
    if (status !== 32'h000C_0000) begin
      failures++;
      $display("FAIL abort_done_clr got=%h exp=%h", status, 32'h000C_0000);
    end
  endtask

  task automatic test_priority();
    logic [50:0] e;
    cfg_write(2'd0, 32'h1);
    step();
    // d=2: abort together with start while busy -> abort wins.
    cfg_write(2'd0, 32'h3);
    checks++;
    if (obs !== {32'h0002_0004, 19'b0}) begin
      failures++;
      $display("FAIL abort_over_start got=%h exp=%h", obs, {32'h0002_0004, 19'b0});
    end
    // start + done_clr in IDLE starts a clean run.
    cfg_write(2'd0, 32'h9);
    for (int d = 1; d <= 4 * AD + 3 + 1; d++) begin
      e = model(d, 8'h10, 8'h20, 3);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL start_clr d=%0d got=%h exp=%h", d, obs, e);
      end
      step();
    end
  endtask

`ifdef TPU_SEQ_IRQ_EN
  task automatic test_irq();
    logic [50:0] e;
    cfg_write(2'd0, 32'hC);
    cfg_write(2'd0, 32'h5);
    for (int d = 1; d <= 22; d++) begin
      e = model(d, 8'h10, 8'h20, 3);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL irq_run d=%0d got=%h exp=%h", d, obs, e);
      end
      checks++;
      if (irq !== (d >= 20)) begin
        failures++;
        $display("FAIL irq_level d=%0d got=%b exp=%b", d, irq, (d >= 20));
      end
      step();
    end
    cfg_write(2'd0, 32'hC);
    checks++;
    if ((irq !== 1'b0) || (status[1] !== 1'b0)) begin
      failures++;
      $display("FAIL irq_clear got=%b%b exp=00", irq, status[1]);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0]  w, ib;
    logic [50:0] e;
    int          n;
    for (int r = 0; r < 6; r++) begin
      w  = 8'($urandom);
      ib = 8'($urandom);
      n  = int'($urandom_range(1, 12));
      cfg_write(2'd1, {24'($urandom), w});
      cfg_write(2'd2, {24'($urandom), ib});
      cfg_write(2'd3, {24'($urandom), 8'(n)});
      cfg_write(2'd0, 32'h1);
      for (int d = 1; d <= 4 * AD + n + 1; d++) begin
        e = model(d, w, ib, n);
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL random r=%0d d=%0d got=%h exp=%h", r, d, obs, e);
        end
        cfg_wr = 1'b0;
        // Writes while busy must not disturb the run in progress.
        if ((d <= 4 * AD + n - 1) && ($urandom_range(0, 3) == 0)) begin
          cfg_wr    = 1'b1;
          cfg_addr  = 2'($urandom_range(0, 3));
          cfg_wdata = (cfg_addr == 2'd0) ? 32'h1 : $urandom;
        end
        step();
      end
      cfg_wr = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [50:0] e;
    cfg_write(2'd1, 32'h33);
    cfg_write(2'd2, 32'h44);
    cfg_write(2'd3, 32'd3);
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 5; d++) begin
      e = model(d, 8'h33, 8'h44, 3);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rst_mid_pre d=%0d got=%h exp=%h", d, obs, e);
      end
      step();
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== 51'b0) begin
      failures++;
      $display("FAIL rst_mid_async got=%h exp=%h", obs, 51'b0);
    end
`ifdef TPU_SEQ_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_irq got=%b exp=0", irq);
    end
`endif
    step();
    reset_n = 1'b1;
    step();
    // Config registers were cleared: WBASE and IBASE restart from 0.
    cfg_write(2'd3, 32'd2);
    cfg_write(2'd0, 32'h1);
    for (int d = 1; d <= 4 * AD + 2 + 1; d++) begin
      e = model(d, 8'h00, 8'h00, 2);
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rst_mid_post d=%0d got=%h exp=%h", d, obs, e);
      end
      step();
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = 2'd0;
    cfg_wdata = 32'h0;
    step();
    test_reset();
    test_zero_rows();
    test_nominal();
    test_wrap();
    test_busy_writes();
    test_abort();
    test_priority();
`ifdef TPU_SEQ_IRQ_EN
    test_irq();
`endif
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
